mem_arbiter: RTL
================

# mem_arbiter

Responder side of the core's memory request protocol. Accepts the hazard unit's instruction-read, data-read and data-write requests, serialises them onto a single RAM port, and returns one-cycle `ihit`/`dhit` completion pulses with load data. Sits between the core and RAM. Data accesses have strict priority over instruction fetch.

## Interface
Parameters:
- `WORD_W`, 32: address and data width.
- `TO_CYCLES`, 255: watchdog limit in cycles. Used only when `MEM_ARB_TIMEOUT_EN` is defined.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `CLK`  in  1  system clock
  - `nRST`  in  1  asynchronous active-low reset
- Requester side:
  - `iREN`  in  1  instruction read request, level-held until `ihit`
  - `iaddr`  in  WORD_W  instruction address
  - `dREN`  in  1  data read request, level-held until `dhit`
  - `dWEN`  in  1  data write request, level-held until `dhit`; never asserted together with `dREN`
  - `daddr`  in  WORD_W  data address
  - `dstore`  in  WORD_W  store data
  - `ihit`  out  1  one-cycle instruction completion pulse
  - `dhit`  out  1  one-cycle data completion pulse
  - `iload`  out  WORD_W  fetched instruction, valid while `ihit`=1
  - `dload`  out  WORD_W  load data, valid while `dhit`=1 after a read
- RAM side:
  - `ramREN`  out  1  RAM read strobe
  - `ramWEN`  out  1  RAM write strobe
  - `ramaddr`  out  WORD_W  RAM address
  - `ramstore`  out  WORD_W  RAM write data
  - `ramload`  in  WORD_W  RAM read data, valid with `ramready`
  - `ramready`  in  1  RAM access complete this cycle
- Error:
  - `merr`  out  1  sticky timeout flag; present only with `MEM_ARB_TIMEOUT_EN`

## Operation
The FSM has three states: IDLE, ACC, RESP.

- **IDLE**
  - If `dREN|dWEN`: latch `daddr`, `dstore` and the read/write kind; set owner=D; go to ACC.
  - Else if `iREN`: latch `iaddr`; set owner=I; go to ACC.
  - Else stay in IDLE.
- **ACC**
  - Drive `ramaddr` and `ramstore` from the latched values.
  - Drive `ramREN` or `ramWEN` from the latched kind. Instruction accesses are always reads.
  - When `ramready`=1: register `ramload` into the owner's load register and go to RESP.
- **RESP**
  - Pulse the owner's hit (`ihit` or `dhit`) for exactly one cycle. The load register is held valid during this cycle.
  - Go to IDLE.

Boundary rules:
- **Request dropped mid-ACC:** the latched access still completes and the hit still pulses. The requester ignores it.
- **Request still high in the cycle after its hit:** the requester clears it by that edge (the hazard unit registers `dfin`). The arbiter samples requests only in IDLE.
- **Simultaneous `iREN` and `dREN`/`dWEN` in IDLE:** data wins. The instruction request is granted in the next IDLE in which no data request is pending.
- **Write completion:** `dhit` pulses and `dload` holds its previous value.
- **`ramready` outside ACC:** ignored.
- **Reset at any point:** abandons the access. State=IDLE. All outputs are 0, including the load registers and `merr`.

## Timing
- Request present in IDLE at cycle N: RAM strobe asserted in cycle N+1.
- With a zero-wait RAM (`ramready`=1 in N+1), the hit is asserted in cycle N+2. This is the minimum latency.
- Each RAM wait cycle adds one cycle of latency.
- Back-to-back accesses have one IDLE cycle between a RESP cycle and the next ACC cycle. Throughput is at most one access per 3 cycles.
- The strobes, `ramaddr` and `ramstore` are registered and glitch-free. They change only on state entry and exit.
- `ihit` and `dhit` are never high in the same cycle.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - A watchdog counter clears on ACC entry and increments each ACC cycle.
  - If it reaches `TO_CYCLES` without `ramready`, the FSM goes to RESP and pulses the owner's hit with load data 0.
  - `merr` sets and stays set until reset.
  - The counter width is `$clog2(TO_CYCLES+1)`.
- Not defined: the `merr` port and the counter do not exist, and ACC waits indefinitely for `ramready`.

## Structure
- Package `mem_arb_pkg` holds:
  - `word_t` (`logic [31:0]`)
  - the state enum `arb_state_t` {IDLE, ACC, RESP}
  - the owner enum {OWN_I, OWN_D}
- Sub-module `mem_arb_wdog` is the timeout counter. Inputs: `clr` and `en`. Output: `expired`. It is instantiated only under `MEM_ARB_TIMEOUT_EN`.

## Test plan
- **Zero-wait instruction read:** `iREN`=1, `iaddr`=0x40, RAM returns 0xDEADBEEF with `ramready` in the first ACC cycle → `ramREN`=1 with `ramaddr`=0x40 at N+1; `ihit`=1 with `iload`=0xDEADBEEF at N+2, for one cycle only.
- **Priority:** `iREN`=1 and `dREN`=1 in the same cycle, `daddr`=0x100 → the data access is served first (`dhit`); `ihit` follows 3 cycles later with a zero-wait RAM.
- **Write with 2 RAM wait cycles:** `dWEN`=1, `daddr`=0x8, `dstore`=0x12345678 → `ramWEN`=1 for 3 cycles with a stable address and data; `dhit` one cycle after `ramready`; `dload` unchanged.
- **Requester drops `dREN` after one ACC cycle** → the access completes and `dhit` still pulses once; the next IDLE grants `iREN`.
- **Reset mid-access:** `nRST` low during ACC → outputs go to 0 asynchronously; after release the FSM is in IDLE and a fresh request completes normally.
- **Timeout (macro defined, `TO_CYCLES`=4):** `ramready` is held 0 → hit with load 0 after 4 ACC cycles; `merr`=1 and remains set through subsequent normal accesses.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter: word type, FSM states and access owner.
package mem_arb_pkg;

  localparam int unsigned WORD_BITS = 32;

  typedef logic [WORD_BITS-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arb_wdog.sv
// Access watchdog: counts ACC cycles and flags expiry on the TO_CYCLES-th one.
// Instantiated by mem_arbiter only when MEM_ARB_TIMEOUT_EN is defined.
module mem_arb_wdog
  import mem_arb_pkg::*;
#(
  parameter int unsigned TO_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TO_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Saturating count so a stalled enable can never wrap back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CNT_W'(TO_CYCLES))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = en && (cnt_q == CNT_W'(TO_CYCLES - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Serialises instruction-read and data-read/write requests onto one RAM port,
// data first. Optional access watchdog and sticky merr with MEM_ARB_TIMEOUT_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned TO_CYCLES = 255
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              ihit,
  output logic              dhit,
  output logic [WORD_W-1:0] iload,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic              ramready
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  output logic              merr
`endif
);

  arb_state_t        state_q, state_d;
  owner_t            own_q, own_d;
  logic              ramren_q, ramren_d;
  logic              ramwen_q, ramwen_d;
  logic [WORD_W-1:0] ramaddr_q, ramaddr_d;
  logic [WORD_W-1:0] ramstore_q, ramstore_d;
  logic              ihit_q, ihit_d;
  logic              dhit_q, dhit_d;
  logic [WORD_W-1:0] iload_q, iload_d;
  logic [WORD_W-1:0] dload_q, dload_d;
  logic              timeout_c;

`ifdef MEM_ARB_TIMEOUT_EN
  logic wd_clr_c;
  logic merr_q;

  assign wd_clr_c = (state_q == IDLE) && (iREN || dREN || dWEN);

  mem_arb_wdog #(
    .TO_CYCLES (TO_CYCLES)
  ) u_wdog (
    .clk     (CLK),
    .rst_n   (nRST),
    .clr     (wd_clr_c),
    .en      (state_q == ACC),
    .expired (timeout_c)
  );

  // Sticky until reset; a late ramready on the expiry cycle still counts as success.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      merr_q <= 1'b0;
    end else if (timeout_c && !ramready) begin
      merr_q <= 1'b1;
    end
  end

  assign merr = merr_q;
`else
  logic unused_cfg;

  assign timeout_c  = 1'b0;
  assign unused_cfg = (TO_CYCLES == 0);
`endif

  // Requests are sampled only in IDLE; the RAM-side registers change only on ACC entry/exit.
  always_comb begin
    state_d    = state_q;
    own_d      = own_q;
    ramren_d   = ramren_q;
    ramwen_d   = ramwen_q;
    ramaddr_d  = ramaddr_q;
    ramstore_d = ramstore_q;
    ihit_d     = 1'b0;
    dhit_d     = 1'b0;
    iload_d    = iload_q;
    dload_d    = dload_q;
    unique case (state_q)
      IDLE: begin
        if (dREN || dWEN) begin
          state_d    = ACC;
          own_d      = OWN_D;
          ramren_d   = ~dWEN;
          ramwen_d   = dWEN;
          ramaddr_d  = daddr;
          ramstore_d = dstore;
        end else if (iREN) begin
          state_d   = ACC;
          own_d     = OWN_I;
          ramren_d  = 1'b1;
          ramwen_d  = 1'b0;
          ramaddr_d = iaddr;
        end
      end
      ACC: begin
        if (ramready || timeout_c) begin
          state_d  = RESP;
          ramren_d = 1'b0;
          ramwen_d = 1'b0;
          if (own_q == OWN_D) begin
            dhit_d = 1'b1;
            if (ramren_q) begin
              dload_d = ramready ? ramload : '0;
            end
          end else begin
            ihit_d  = 1'b1;
            iload_d = ramready ? ramload : '0;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      own_q      <= OWN_I;
      ramren_q   <= 1'b0;
      ramwen_q   <= 1'b0;
      ramaddr_q  <= '0;
      ramstore_q <= '0;
      ihit_q     <= 1'b0;
      dhit_q     <= 1'b0;
      iload_q    <= '0;
      dload_q    <= '0;
    end else begin
      state_q    <= state_d;
      own_q      <= own_d;
      ramren_q   <= ramren_d;
      ramwen_q   <= ramwen_d;
      ramaddr_q  <= ramaddr_d;
      ramstore_q <= ramstore_d;
      ihit_q     <= ihit_d;
      dhit_q     <= dhit_d;
      iload_q    <= iload_d;
      dload_q    <= dload_d;
    end
  end

  assign ramREN   = ramren_q;
  assign ramWEN   = ramwen_q;
  assign ramaddr  = ramaddr_q;
  assign ramstore = ramstore_q;
  assign ihit     = ihit_q;
  assign dhit     = dhit_q;
  assign iload    = iload_q;
  assign dload    = dload_q;

endmodule
